// File: rtl/nibble_latch_writer.sv
// Write-side driver for 4-bit latch netlists: valid/ready word intake, timed setup/pulse/hold enable.
// Optional readback check via macro NIBBLE_LATCH_WRITER_VERIFY_EN (adds VERIFY state and err).
module nibble_latch_writer #(
   parameter int DATA_W    = 4,
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] lat_d,
   output logic              lat_en,
   input  logic [DATA_W-1:0] lat_q,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_HOLD
`ifdef NIBBLE_LATCH_WRITER_VERIFY_EN
      , S_VERIFY
`endif
   } state_t;

   // counter holds N-1 on entry so each window lasts exactly N cycles
   localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
   localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
   localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] lat_d_d;
   logic              lat_en_d;
   logic              done_d;
   logic              err_q, err_d;
   logic              cnt_zero;

   assign in_ready = (state_q == S_IDLE) && !rst;
   assign cnt_zero = (cnt_q == 8'd0);

`ifdef NIBBLE_LATCH_WRITER_VERIFY_EN
   logic [DATA_W-1:0] q_s1, q_s2;
   logic              sync_en;

   // readback synchroniser runs from HOLD entry through VERIFY
   assign sync_en = (state_d == S_HOLD) || (state_q == S_HOLD) || (state_q == S_VERIFY);

   always_ff @(posedge clk) begin
      if (rst) begin
         q_s1 <= '0;
         q_s2 <= '0;
      end else if (sync_en) begin
         q_s1 <= lat_q;
         q_s2 <= q_s1;
      end
   end
`else
   logic unused_lat_q;
   assign unused_lat_q = ^lat_q;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lat_d_d  = lat_d;
      lat_en_d = lat_en;
      done_d   = 1'b0;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               state_d = S_SETUP;
               cnt_d   = SETUP_LD;
               lat_d_d = in_data;
               err_d   = 1'b0;
            end
         end
         S_SETUP: begin
            if (cnt_zero) begin
               state_d  = S_PULSE;
               cnt_d    = PULSE_LD;
               lat_en_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_PULSE: begin
            if (cnt_zero) begin
               state_d  = S_HOLD;
               cnt_d    = HOLD_LD;
               lat_en_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_HOLD: begin
            if (cnt_zero) begin
`ifdef NIBBLE_LATCH_WRITER_VERIFY_EN
               state_d = S_VERIFY;
               cnt_d   = 8'd0;
`else
               state_d = S_IDLE;
               done_d  = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
`ifdef NIBBLE_LATCH_WRITER_VERIFY_EN
         S_VERIFY: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = (q_s2 != lat_d);
         end
`endif
         default: begin
            state_d  = S_IDLE;
            cnt_d    = 8'd0;
            lat_en_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         lat_d   <= '0;
         lat_en  <= 1'b0;
         done    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lat_d   <= lat_d_d;
         lat_en  <= lat_en_d;
         done    <= done_d;
         err_q   <= err_d;
      end
   end

`ifdef NIBBLE_LATCH_WRITER_VERIFY_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_latch_writer.sv
// Scoreboard bench for nibble_latch_writer: default-parameter DUT plus two parameter-corner instances.
module tb_nibble_latch_writer;
   localparam int S = 2, P = 2, H = 1;
`ifdef NIBBLE_LATCH_WRITER_VERIFY_EN
   localparam int VX = 1;
`else
   localparam int VX = 0;
`endif
   localparam int LAT = S + P + H + VX;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_s = 1'b1;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_s <= rst;
   end

   logic       a_valid = 1'b0, a_ready, a_lat_en, a_done, a_err;
   logic [3:0] a_data = 4'h0, a_lat_d, a_lat_q;
   logic [3:0] a_latch = 4'h0;
   logic       force_bad = 1'b0;

   // behavioural latch: transparent while enable is high
   always @(a_lat_en or a_lat_d) if (a_lat_en) a_latch = a_lat_d;
   assign a_lat_q = force_bad ? 4'h0 : a_latch;

   nibble_latch_writer #(.DATA_W(4), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) u_a (
      .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
      .lat_d(a_lat_d), .lat_en(a_lat_en), .lat_q(a_lat_q), .done(a_done), .err(a_err));

   logic       b_valid = 1'b0, b_ready, b_lat_en, b_done, b_err;
   logic [3:0] b_data = 4'h0, b_lat_d;
   nibble_latch_writer #(.DATA_W(4), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) u_b (
      .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
      .lat_d(b_lat_d), .lat_en(b_lat_en), .lat_q(b_lat_d), .done(b_done), .err(b_err));

   logic       c_valid = 1'b0, c_ready, c_lat_en, c_done, c_err;
   logic [3:0] c_data = 4'h0, c_lat_d;
   nibble_latch_writer #(.DATA_W(4), .SETUP_CYC(255), .PULSE_CYC(1), .HOLD_CYC(1)) u_c (
      .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready), .in_data(c_data),
      .lat_d(c_lat_d), .lat_en(c_lat_en), .lat_q(c_lat_d), .done(c_done), .err(c_err));

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, exp, cyc);
   endtask

   typedef struct {
      logic [3:0] data;
      int         t0;
      logic       exp_err;
   } item_t;
   item_t sb[$];

   // cycle-accurate scoreboard monitor for u_a
   always @(negedge clk) begin
      if (rst_s) begin
         sb.delete();
         chk("rst_en", a_lat_en, 1'b0);
         chk("rst_d", a_lat_d, 4'h0);
         chk("rst_done", a_done, 1'b0);
         chk("rst_err", a_err, 1'b0);
         chk("rst_ready", a_ready, !rst);
      end else begin
         if (sb.size() > 0 && cyc >= sb[0].t0) begin
            int k;
            k = cyc - sb[0].t0;
            chk("lat_en", a_lat_en, (k >= S) && (k < S + P));
            chk("lat_d", a_lat_d, sb[0].data);
            chk("done", a_done, k == LAT);
            if (k == 0) chk("err_clr", a_err, 1'b0);
            if (k == LAT) begin
               chk("err", a_err, sb[0].exp_err);
               void'(sb.pop_front());
            end
         end else begin
            chk("idle_en", a_lat_en, 1'b0);
            chk("idle_done", a_done, 1'b0);
         end
         chk("ready", a_ready, !rst && (sb.size() == 0 || cyc < sb[0].t0));
         if (a_valid && a_ready && !rst) begin
            item_t it;
            it.data = a_data;
            it.t0 = cyc + 1;
`ifdef NIBBLE_LATCH_WRITER_VERIFY_EN
            it.exp_err = force_bad && (a_data != 4'h0);
`else
            it.exp_err = 1'b0;
`endif
            sb.push_back(it);
         end
      end
   end

   task automatic wait_ready();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (a_ready) break;
      end
   endtask

   task automatic send(input logic [3:0] d);
      @(posedge clk); #1;
      a_valid = 1'b1;
      a_data = d;
      wait_ready();
      chk("accept_timeout", a_ready, 1'b1);
      @(posedge clk); #1;
      a_valid = 1'b0;
   endtask

   task automatic send2(input logic [3:0] d1, input logic [3:0] d2);
      @(posedge clk); #1;
      a_valid = 1'b1;
      a_data = d1;
      wait_ready();
      @(posedge clk); #1;
      a_data = d2;
      wait_ready();
      chk("b2b_ready", a_ready, 1'b1);
      chk("b2b_done", a_done, 1'b1);
      @(posedge clk); #1;
      a_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (sb.size() == 0) break;
      end
      @(negedge clk);
      chk("drain", sb.size(), 0);
   endtask

   task automatic corner(input bit use_c, input int s, input int p, input int h, input logic [3:0] d);
      int   t0, rise, wid, dn;
      logic en, dv, rdy;
      logic [3:0] ld;
      rise = -1; wid = 0; dn = -1;
      @(posedge clk); #1;
      if (use_c) begin c_valid = 1'b1; c_data = d; end
      else begin b_valid = 1'b1; b_data = d; end
      @(negedge clk);
      rdy = use_c ? c_ready : b_ready;
      chk("cr_ready", rdy, 1'b1);
      t0 = cyc + 1;
      @(posedge clk); #1;
      c_valid = 1'b0;
      b_valid = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         en = use_c ? c_lat_en : b_lat_en;
         dv = use_c ? c_done : b_done;
         ld = use_c ? c_lat_d : b_lat_d;
         if (en) begin
            if (rise < 0) rise = cyc;
            wid++;
         end
         if (dv) begin
            dn = cyc;
            break;
         end
      end
      chk("cr_rise", rise - t0, s);
      chk("cr_width", wid, p);
      chk("cr_latency", dn - t0, s + p + h + VX);
      chk("cr_lat_d", ld, d);
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      send(4'hA);
      drain();

      send2(4'h3, 4'hC);
      drain();

      for (int i = 0; i < 6; i++) begin
         send(4'($urandom_range(15)));
         repeat ($urandom_range(3)) @(posedge clk);
         drain();
      end

      // reset lands on the cycle after the pulse rise
      send(4'h9);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (8) @(negedge clk);

      force_bad = 1'b1;
      send(4'h5);
      drain();
      force_bad = 1'b0;
      send(4'h6);
      drain();

      corner(1'b0, 1, 1, 1, 4'hF);
      corner(1'b1, 255, 1, 1, 4'hF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
